bp_axil_host_mmio: RTL and testbench

BP_AXIL_HOST_MMIO -- requirements
Module: bp_axil_host_mmio

---
 rtl/bp_axil_host_mmio.sv | 229 ++++++++++++++++++++++
 tb/tb_bp_axil_host_mmio.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_axil_host_mmio.sv
// AXI4-lite host MMIO slave: putchar FIFO, sticky finish flag/code, status register.
// Define BP_AXIL_HOST_MMIO_SCRATCH_EN to map a byte-maskable scratch register at offset 0x18.
module bp_axil_host_mmio #(
  parameter int axi_lite_addr_width_p = 32,
  parameter int axi_lite_data_width_p = 64,
  parameter int fifo_els_p            = 8
) (
  input  logic                               clk_i,
  input  logic                               reset_i,
  input  logic [axi_lite_addr_width_p-1:0]   s_axi_lite_awaddr_i,
  input  logic [2:0]                         s_axi_lite_awprot_i,
  input  logic                               s_axi_lite_awvalid_i,
  output logic                               s_axi_lite_awready_o,
  input  logic [axi_lite_data_width_p-1:0]   s_axi_lite_wdata_i,
  input  logic [axi_lite_data_width_p/8-1:0] s_axi_lite_wstrb_i,
  input  logic                               s_axi_lite_wvalid_i,
  output logic                               s_axi_lite_wready_o,
  output logic [1:0]                         s_axi_lite_bresp_o,
  output logic                               s_axi_lite_bvalid_o,
  input  logic                               s_axi_lite_bready_i,
  input  logic [axi_lite_addr_width_p-1:0]   s_axi_lite_araddr_i,
  input  logic [2:0]                         s_axi_lite_arprot_i,
  input  logic                               s_axi_lite_arvalid_i,
  output logic                               s_axi_lite_arready_o,
  output logic [axi_lite_data_width_p-1:0]   s_axi_lite_rdata_o,
  output logic [1:0]                         s_axi_lite_rresp_o,
  output logic                               s_axi_lite_rvalid_o,
  input  logic                               s_axi_lite_rready_i,
  output logic                               char_v_o,
  output logic [7:0]                         char_o,
  input  logic                               char_yumi_i,
  output logic                               finish_o,
  output logic [7:0]                         finish_code_o
);

  localparam int strb_w_lp = axi_lite_data_width_p / 8;
  localparam int ptr_w_lp  = (fifo_els_p > 1) ? $clog2(fifo_els_p) : 1;
  localparam int cnt_w_lp  = $clog2(fifo_els_p + 1);
  localparam logic [1:0] resp_okay_lp   = 2'b00;
  localparam logic [1:0] resp_slverr_lp = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_RESP} r_state_e;

  w_state_e w_state_q, w_state_d;
  r_state_e r_state_q, r_state_d;
  logic                             bvalid_q, bvalid_d;
  logic [1:0]                       bresp_q, bresp_d;
  logic                             rvalid_q, rvalid_d;
  logic [1:0]                       rresp_q, rresp_d;
  logic [axi_lite_data_width_p-1:0] rdata_q, rdata_d;
  logic                             finish_q, finish_d;
  logic [7:0]                       finish_code_q, finish_code_d;
  logic [7:0]                       fifo_mem_q [fifo_els_p];
  logic [ptr_w_lp-1:0]              wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [cnt_w_lp-1:0]              count_q, count_d;

  logic [7:0] waddr, raddr;
  logic       w_putchar, w_finish, w_scratch, w_mapped;
  logic       fifo_full, fifo_empty, w_accept, r_accept, enq, deq;
  logic       scratch_mapped;
  logic [axi_lite_data_width_p-1:0] scratch_rdata, status_rdata;

  // Only the low address byte decodes; prot and upper address bits are don't-care.
  logic unused_inputs;
  assign unused_inputs = ^{s_axi_lite_awprot_i, s_axi_lite_arprot_i,
                           s_axi_lite_awaddr_i, s_axi_lite_araddr_i,
                           s_axi_lite_wdata_i, s_axi_lite_wstrb_i};

  assign waddr      = s_axi_lite_awaddr_i[7:0];
  assign raddr      = s_axi_lite_araddr_i[7:0];
  assign w_putchar  = (waddr == 8'h00);
  assign w_finish   = (waddr == 8'h10);
  assign w_scratch  = scratch_mapped && (waddr == 8'h18);
  assign w_mapped   = w_putchar || w_finish || w_scratch;

  assign fifo_full  = (count_q == cnt_w_lp'(fifo_els_p));
  assign fifo_empty = (count_q == '0);

  // Fullness comes from the registered count, so a same-cycle pop cannot unblock a putchar.
  assign w_accept = (w_state_q == W_IDLE) && s_axi_lite_awvalid_i && s_axi_lite_wvalid_i
                    && !(w_putchar && fifo_full);
  assign r_accept = (r_state_q == R_IDLE) && s_axi_lite_arvalid_i;
  assign enq      = w_accept && w_putchar && s_axi_lite_wstrb_i[0];
  assign deq      = char_yumi_i && !fifo_empty;

`ifdef BP_AXIL_HOST_MMIO_SCRATCH_EN
  logic [axi_lite_data_width_p-1:0] scratch_q, scratch_d;
  logic                             scratch_we;

  assign scratch_mapped = 1'b1;
  assign scratch_we     = w_accept && w_scratch;
  assign scratch_rdata  = scratch_q;

  for (genvar gi = 0; gi < strb_w_lp; gi++) begin : g_scratch_byte
    assign scratch_d[gi*8 +: 8] = (scratch_we && s_axi_lite_wstrb_i[gi])
                                  ? s_axi_lite_wdata_i[gi*8 +: 8] : scratch_q[gi*8 +: 8];
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) scratch_q <= '0;
    else         scratch_q <= scratch_d;
  end
`else
  assign scratch_mapped = 1'b0;
  assign scratch_rdata  = '0;
`endif

  always_comb begin
    status_rdata        = '0;
    status_rdata[15:8]  = finish_code_q;
    status_rdata[7]     = finish_q;
    status_rdata[4:0]   = 5'(count_q);
  end

  always_comb begin
    w_state_d     = w_state_q;
    bvalid_d      = bvalid_q;
    bresp_d       = bresp_q;
    finish_d      = finish_q;
    finish_code_d = finish_code_q;
    case (w_state_q)
      W_IDLE: begin
        if (w_accept) begin
          w_state_d = W_RESP;
          bvalid_d  = 1'b1;
          bresp_d   = w_mapped ? resp_okay_lp : resp_slverr_lp;
          if (w_finish) begin
            finish_d      = 1'b1;
            finish_code_d = s_axi_lite_wdata_i[7:0];
          end
        end
      end
      W_RESP: begin
        if (s_axi_lite_bready_i) begin
          w_state_d = W_IDLE;
          bvalid_d  = 1'b0;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Read data is captured from current state, so a colliding write is not yet visible.
  always_comb begin
    r_state_d = r_state_q;
    rvalid_d  = rvalid_q;
    rresp_d   = rresp_q;
    rdata_d   = rdata_q;
    case (r_state_q)
      R_IDLE: begin
        if (r_accept) begin
          r_state_d = R_RESP;
          rvalid_d  = 1'b1;
          rresp_d   = resp_okay_lp;
          if (raddr == 8'h08) begin
            rdata_d = status_rdata;
          end else if (scratch_mapped && (raddr == 8'h18)) begin
            rdata_d = scratch_rdata;
          end else begin
            rdata_d = '0;
            rresp_d = resp_slverr_lp;
          end
        end
      end
      R_RESP: begin
        if (s_axi_lite_rready_i) begin
          r_state_d = R_IDLE;
          rvalid_d  = 1'b0;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + ptr_w_lp'(enq);
    rd_ptr_d = rd_ptr_q + ptr_w_lp'(deq);
    count_d  = count_q + cnt_w_lp'(enq) - cnt_w_lp'(deq);
  end

  always_ff @(posedge clk_i) begin
    if (enq) fifo_mem_q[wr_ptr_q] <= s_axi_lite_wdata_i[7:0];
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      w_state_q     <= W_IDLE;
      r_state_q     <= R_IDLE;
      bvalid_q      <= 1'b0;
      bresp_q       <= 2'b00;
      rvalid_q      <= 1'b0;
      rresp_q       <= 2'b00;
      rdata_q       <= '0;
      finish_q      <= 1'b0;
      finish_code_q <= 8'h00;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      w_state_q     <= w_state_d;
      r_state_q     <= r_state_d;
      bvalid_q      <= bvalid_d;
      bresp_q       <= bresp_d;
      rvalid_q      <= rvalid_d;
      rresp_q       <= rresp_d;
      rdata_q       <= rdata_d;
      finish_q      <= finish_d;
      finish_code_q <= finish_code_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
    end
  end

  assign s_axi_lite_awready_o = w_accept;
  assign s_axi_lite_wready_o  = w_accept;
  assign s_axi_lite_bvalid_o  = bvalid_q;
  assign s_axi_lite_bresp_o   = bresp_q;
  assign s_axi_lite_arready_o = (r_state_q == R_IDLE);
  assign s_axi_lite_rvalid_o  = rvalid_q;
  assign s_axi_lite_rresp_o   = rresp_q;
  assign s_axi_lite_rdata_o   = rdata_q;
  assign char_v_o             = !fifo_empty;
  assign char_o               = fifo_empty ? 8'h00 : fifo_mem_q[rd_ptr_q];
  assign finish_o             = finish_q;
  assign finish_code_o        = finish_code_q;

endmodule

// File: tb/tb_bp_axil_host_mmio.sv
// Bench for bp_axil_host_mmio: directed vector table, multi-cycle corner sequences,
// and random AXI-lite traffic checked against a queue-based reference model.
`timescale 1ns/1ps
module tb_bp_axil_host_mmio;
  localparam int FIFO_ELS = 8;
`ifdef BP_AXIL_HOST_MMIO_SCRATCH_EN
  localparam bit SCRATCH_EN = 1'b1;
`else
  localparam bit SCRATCH_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_i;
  logic [31:0] awaddr;  logic [2:0] awprot;  logic awvalid, awready;
  logic [63:0] wdata;   logic [7:0] wstrb;   logic wvalid, wready;
  logic [1:0]  bresp;   logic bvalid, bready;
  logic [31:0] araddr;  logic [2:0] arprot;  logic arvalid, arready;
  logic [63:0] rdata;   logic [1:0] rresp;   logic rvalid, rready;
  logic        char_v;  logic [7:0] char_o;  logic yumi;
  logic        finish;  logic [7:0] finish_code;

  int checks = 0;
  int errors = 0;

  bp_axil_host_mmio dut (
    .clk_i(clk), .reset_i(reset_i),
    .s_axi_lite_awaddr_i(awaddr), .s_axi_lite_awprot_i(awprot),
    .s_axi_lite_awvalid_i(awvalid), .s_axi_lite_awready_o(awready),
    .s_axi_lite_wdata_i(wdata), .s_axi_lite_wstrb_i(wstrb),
    .s_axi_lite_wvalid_i(wvalid), .s_axi_lite_wready_o(wready),
    .s_axi_lite_bresp_o(bresp), .s_axi_lite_bvalid_o(bvalid), .s_axi_lite_bready_i(bready),
    .s_axi_lite_araddr_i(araddr), .s_axi_lite_arprot_i(arprot),
    .s_axi_lite_arvalid_i(arvalid), .s_axi_lite_arready_o(arready),
    .s_axi_lite_rdata_o(rdata), .s_axi_lite_rresp_o(rresp),
    .s_axi_lite_rvalid_o(rvalid), .s_axi_lite_rready_i(rready),
    .char_v_o(char_v), .char_o(char_o), .char_yumi_i(yumi),
    .finish_o(finish), .finish_code_o(finish_code)
  );

  // Reference model
  logic [7:0]  ref_q[$];
  logic        ref_finish;
  logic [7:0]  ref_code;
  logic [63:0] ref_scratch;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] ref_status();
    return {48'h0, ref_code, ref_finish, 2'b00, 5'(ref_q.size())};
  endfunction

  function automatic logic [1:0] ref_write(input logic [31:0] a, input logic [63:0] d,
                                           input logic [7:0] s);
    if (a[7:0] == 8'h00) begin
      if (s[0]) ref_q.push_back(d[7:0]);
      return 2'b00;
    end
    if (a[7:0] == 8'h10) begin
      ref_finish = 1'b1;
      ref_code   = d[7:0];
      return 2'b00;
    end
    if (a[7:0] == 8'h18 && SCRATCH_EN) begin
      for (int b = 0; b < 8; b++) if (s[b]) ref_scratch[b*8 +: 8] = d[b*8 +: 8];
      return 2'b00;
    end
    return 2'b10;
  endfunction

  function automatic logic [1:0] ref_read(input logic [31:0] a, output logic [63:0] d);
    d = '0;
    if (a[7:0] == 8'h08) begin
      d = ref_status();
      return 2'b00;
    end
    if (a[7:0] == 8'h18 && SCRATCH_EN) begin
      d = ref_scratch;
      return 2'b00;
    end
    return 2'b10;
  endfunction

  task automatic do_reset();
    reset_i = 1'b1;
    awvalid = 0; wvalid = 0; arvalid = 0; bready = 0; rready = 0; yumi = 0;
    repeat (2) @(posedge clk);
    #1 reset_i = 1'b0;
    ref_q.delete();
    ref_finish = 0; ref_code = 0; ref_scratch = 0;
  endtask

  // All tasks start and end 1ns after a rising edge.
  task automatic axi_write(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s,
                           output logic [1:0] resp);
    logic acc;
    int   n;
    awaddr = a; wdata = d; wstrb = s; awprot = 3'($urandom_range(0, 7));
    awvalid = 1; wvalid = 1;
    acc = 0; n = 0;
    while (!acc && n < 20) begin
      #1 acc = awready && wready;
      @(posedge clk); #1;
      n++;
    end
    awvalid = 0; wvalid = 0;
    if (!acc) begin
      chk("aw_accept_timeout", 0, 1);
      resp = 2'b11;
      return;
    end
    chk("bvalid_after_accept", bvalid, 1);
    resp = bresp;
    bready = 1;
    @(posedge clk); #1;
    bready = 0;
    chk("bvalid_cleared", bvalid, 0);
    $display("WR addr=%08h data=%016h strb=%02h bresp=%02b", a, d, s, resp);
  endtask

  task automatic axi_read(input logic [31:0] a, output logic [63:0] d, output logic [1:0] resp);
    araddr = a; arprot = 3'($urandom_range(0, 7)); arvalid = 1;
    #1 chk("arready_idle", arready, 1);
    @(posedge clk); #1;
    arvalid = 0;
    chk("rvalid_after_accept", rvalid, 1);
    d = rdata; resp = rresp;
    rready = 1;
    @(posedge clk); #1;
    rready = 0;
    chk("rvalid_cleared", rvalid, 0);
    $display("RD addr=%08h rdata=%016h rresp=%02b", a, d, resp);
  endtask

  task automatic pop_expect(input logic [7:0] exp);
    chk("char_v_before_pop", char_v, 1);
    chk("char_o_head", char_o, exp);
    yumi = 1;
    @(posedge clk); #1;
    yumi = 0;
    $display("POP char=%02h", char_o);
  endtask

  typedef struct {
    logic        is_read;
    logic [31:0] addr;
    logic [63:0] data;
    logic [7:0]  strb;
    logic [1:0]  exp_resp;
    logic [63:0] exp_rdata;
  } vec_t;

  vec_t vecs[18];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  resp, eresp;
    logic [63:0] d, ed;
    logic [31:0] r, a;
    logic [7:0]  s;
    logic [7:0]  unm_w[4];
    logic [7:0]  rd_sel[5];

    vecs[0]  = '{0, 32'h0000_0000, 64'h41,   8'hFF, 2'b00, 64'h0};
    vecs[1]  = '{1, 32'h0000_0008, 64'h0,    8'h00, 2'b00, 64'h01};
    vecs[2]  = '{0, 32'h0000_0000, 64'h42,   8'hFE, 2'b00, 64'h0};
    vecs[3]  = '{1, 32'h0000_0008, 64'h0,    8'h00, 2'b00, 64'h01};
    vecs[4]  = '{0, 32'h0000_0010, 64'h03,   8'hFF, 2'b00, 64'h0};
    vecs[5]  = '{1, 32'h0000_0008, 64'h0,    8'h00, 2'b00, 64'h0381};
    vecs[6]  = '{0, 32'h0000_0008, 64'hDEAD, 8'hFF, 2'b10, 64'h0};
    vecs[7]  = '{1, 32'h0000_0020, 64'h0,    8'h00, 2'b10, 64'h0};
    vecs[8]  = '{1, 32'h0000_0000, 64'h0,    8'h00, 2'b10, 64'h0};
    vecs[9]  = '{1, 32'h0000_0010, 64'h0,    8'h00, 2'b10, 64'h0};
    vecs[10] = '{0, 32'h0000_0018, 64'h1122334455667788, 8'h0F,
                 SCRATCH_EN ? 2'b00 : 2'b10, 64'h0};
    vecs[11] = '{1, 32'h0000_0018, 64'h0, 8'h00,
                 SCRATCH_EN ? 2'b00 : 2'b10, SCRATCH_EN ? 64'h55667788 : 64'h0};
    vecs[12] = '{0, 32'h0000_0010, 64'hA7,   8'h01, 2'b00, 64'h0};
    vecs[13] = '{1, 32'h0000_0008, 64'h0,    8'h00, 2'b00, 64'hA781};
    vecs[14] = '{0, 32'h0000_0300, 64'h5A,   8'h01, 2'b00, 64'h0};
    vecs[15] = '{1, 32'h0000_0508, 64'h0,    8'h00, 2'b00, 64'hA782};
    vecs[16] = '{0, 32'h0000_0020, 64'h77,   8'hFF, 2'b10, 64'h0};
    vecs[17] = '{1, 32'h0000_0008, 64'h0,    8'h00, 2'b00, 64'hA782};

    awaddr = 0; wdata = 0; wstrb = 0; araddr = 0; awprot = 0; arprot = 0;
    do_reset();

    // Reset state
    chk("rst_awready", awready, 0);
    chk("rst_wready", wready, 0);
    chk("rst_arready", arready, 1);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_bresp", bresp, 0);
    chk("rst_rresp", rresp, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_char_v", char_v, 0);
    chk("rst_char_o", char_o, 0);
    chk("rst_finish", finish, 0);
    chk("rst_finish_code", finish_code, 0);

    // Directed vector table
    for (int i = 0; i < 18; i++) begin
      if (vecs[i].is_read) begin
        axi_read(vecs[i].addr, d, resp);
        chk($sformatf("vec%0d_rresp", i), resp, vecs[i].exp_resp);
        chk($sformatf("vec%0d_rdata", i), d, vecs[i].exp_rdata);
      end else begin
        axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, resp);
        chk($sformatf("vec%0d_bresp", i), resp, vecs[i].exp_resp);
      end
    end
    chk("tbl_finish", finish, 1);
    chk("tbl_finish_code", finish_code, 8'hA7);
    pop_expect(8'h41);
    pop_expect(8'h5A);
    chk("tbl_fifo_empty", char_v, 0);

    // FIFO full backpressure and same-cycle pop
    do_reset();
    for (int i = 0; i < FIFO_ELS; i++) begin
      axi_write(32'h0, 64'(8'h30 + i), 8'h01, resp);
      chk("fill_bresp", resp, 0);
    end
    axi_read(32'h8, d, resp);
    chk("full_count", d[4:0], 5'(FIFO_ELS));
    awaddr = 0; wdata = 64'h39; wstrb = 8'h01; awvalid = 1; wvalid = 1;
    #1 chk("full_stall_0", {awready, wready}, 2'b00);
    @(posedge clk); #1;
    chk("full_stall_1", {awready, wready}, 2'b00);
    yumi = 1;
    #1 chk("full_stall_same_cycle_pop", {awready, wready}, 2'b00);
    @(posedge clk); #1;
    yumi = 0;
    #1 chk("full_unstall_next", {awready, wready}, 2'b11);
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0;
    chk("ninth_bvalid", bvalid, 1);
    chk("ninth_bresp", bresp, 0);
    bready = 1; @(posedge clk); #1; bready = 0;
    for (int i = 1; i < FIFO_ELS; i++) pop_expect(8'(8'h30 + i));
    pop_expect(8'h39);
    chk("drain_empty", char_v, 0);

    // Simultaneous read and write: read returns pre-write status
    awaddr = 32'h10; wdata = 64'h09; wstrb = 8'hFF; awvalid = 1; wvalid = 1;
    araddr = 32'h08; arvalid = 1;
    #1 chk("rw_both_ready", {awready, arready}, 2'b11);
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0; arvalid = 0;
    chk("rw_pre_write_rdata", rdata, 64'h0);
    chk("rw_finish_after", {finish, finish_code}, {1'b1, 8'h09});
    bready = 1; rready = 1; @(posedge clk); #1; bready = 0; rready = 0;

    // Held responses, then reset mid-transaction
    axi_write(32'h0, 64'h55, 8'h01, resp);
    awaddr = 32'h10; wdata = 64'h22; awvalid = 1; wvalid = 1;
    araddr = 32'h08; arvalid = 1;
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0; arvalid = 0;
    for (int i = 0; i < 3; i++) begin
      chk("hold_bvalid", {bvalid, bresp}, 3'b100);
      chk("hold_rdata", {rvalid, rdata}, {1'b1, 64'h0981});
      #1 chk("hold_no_accept", {awready, arready}, 2'b00);
      @(posedge clk); #1;
    end
    reset_i = 1;
    @(posedge clk); #1;
    reset_i = 0;
    chk("midrst_bvalid", bvalid, 0);
    chk("midrst_rvalid", rvalid, 0);
    chk("midrst_char_v", char_v, 0);
    chk("midrst_finish", {finish, finish_code}, 9'h0);
    chk("midrst_arready", arready, 1);
    ref_q.delete(); ref_finish = 0; ref_code = 0; ref_scratch = 0;

    // Random traffic against the reference model
    unm_w  = '{8'h08, 8'h20, 8'h04, 8'h28};
    rd_sel = '{8'h18, 8'h20, 8'h00, 8'h10, 8'hF8};
    for (int it = 0; it < 300; it++) begin
      r = $urandom;
      case ($urandom_range(0, 9))
        0, 1, 2: begin
          if (ref_q.size() == FIFO_ELS) begin
            pop_expect(ref_q[0]);
            void'(ref_q.pop_front());
          end
          a = {r[31:8], 8'h00};
          d = {$urandom, $urandom};
          s = 8'($urandom);
          eresp = ref_write(a, d, s);
          axi_write(a, d, s, resp);
          chk("rnd_putchar_bresp", resp, eresp);
        end
        3: begin
          a = {r[31:8], 8'h10}; d = 64'($urandom); s = 8'($urandom);
          eresp = ref_write(a, d, s);
          axi_write(a, d, s, resp);
          chk("rnd_finish_bresp", resp, eresp);
        end
        4: begin
          a = {r[31:8], 8'h18}; d = {$urandom, $urandom}; s = 8'($urandom);
          eresp = ref_write(a, d, s);
          axi_write(a, d, s, resp);
          chk("rnd_scratch_bresp", resp, eresp);
        end
        5: begin
          a = {r[31:8], unm_w[r[1:0]]}; d = {$urandom, $urandom}; s = 8'hFF;
          eresp = ref_write(a, d, s);
          axi_write(a, d, s, resp);
          chk("rnd_unmapped_bresp", resp, eresp);
        end
        6: begin
          a = {r[31:8], 8'h08};
          eresp = ref_read(a, ed);
          axi_read(a, d, resp);
          chk("rnd_status_rresp", resp, eresp);
          chk("rnd_status_rdata", d, ed);
        end
        7: begin
          a = {r[31:8], rd_sel[$urandom_range(0, 4)]};
          eresp = ref_read(a, ed);
          axi_read(a, d, resp);
          chk("rnd_read_rresp", resp, eresp);
          chk("rnd_read_rdata", d, ed);
        end
        default: begin
          if (ref_q.size() > 0) begin
            pop_expect(ref_q[0]);
            void'(ref_q.pop_front());
          end else begin
            chk("rnd_empty_char_v", char_v, 0);
          end
        end
      endcase
      chk("rnd_finish_out", {finish, finish_code}, {ref_finish, ref_code});
    end
    while (ref_q.size() > 0) begin
      pop_expect(ref_q[0]);
      void'(ref_q.pop_front());
    end
    chk("final_empty", char_v, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
